shift_sequencer: RTL
====================

# shift_sequencer

Multi-bit shift controller for the 8-bit single-step shift unit in the multicycle processor datapath. It accepts a shift request (operation, amount 0–7, operand) from the control FSM and drives the shift unit's `control`/`data` inputs. It iterates one bit position per clock, feeding the shift unit output back into an internal working register. It returns the result with carry-out and zero flags, plus a one-cycle `done` pulse.

## Interface
Parameters:
- AMT_W, 3, width of the shift-amount field; maximum amount is 2^AMT_W−1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request strobe; sampled only while ready=1.
- op  in  3  operation: 000 ROL, 001 ROR, 010 LSL, 011 ASR, 100 LSR; 101–111 illegal.
- amount  in  AMT_W  number of single-bit steps.
- data_in  in  8  operand.
- shift_ctrl  out  3  to shift unit `control`.
- shift_data  out  8  to shift unit `data`.
- shift_out  in  8  from shift unit `out` (combinational return).
- ready  out  1  high in IDLE; request can be accepted.
- done  out  1  one-cycle pulse; result/flags valid.
- result  out  8  final shifted value; held until next accepted request.
- carry  out  1  last bit shifted/rotated out; 0 if amount=0.
- zero  out  1  result==0, registered at completion.
- err  out  1  set at completion of an illegal-op request; cleared at next accept.

## Operation
- Registers: state, work[7:0], cnt[AMT_W-1:0], op_r[2:0], result, carry, zero, err.
- shift_data = work; shift_ctrl = op_r. op_r only ever holds a legal code, because the shift unit holds its previous output for codes 101–111.
- IDLE (ready=1): on start=1 at edge:
  - op legal, amount>0: work←data_in, cnt←amount, op_r←op, err←0, carry←0; go to RUN.
  - op legal, amount=0: work←data_in, err←0, carry←0; go to DONE.
  - op illegal: work←data_in, err←1, carry←0, op_r unchanged; go to DONE.
- RUN (ready=0): each edge, work←shift_out, cnt←cnt−1, carry←outgoing bit.
  - Outgoing bit is work[7] for ROL/LSL and work[0] for ROR/ASR/LSR.
  - When cnt==1 at the edge, go to DONE.
- DONE (ready=0): done=1 this cycle only. result and zero are loaded at entry to DONE, so they are valid while done=1. result←final value of work, zero←(that value==0). Next edge goes to IDLE.
- start outside IDLE is ignored and not queued.
- Inputs op, amount and data_in are not used after the accept edge.

## Timing
- Number edges from the accept edge E0 (start=1 in IDLE before E0).
- Amount N>0: shifts occur at edges E1..EN. done=1 in the cycle after EN. ready returns at EN+1.
- Amount 0 or illegal op: done=1 in the cycle after E0. ready returns at E1.
- Worst-case latency (N=7): done 8 cycles after the start cycle. Back-to-back throughput is one request per N+2 cycles.
- Reset (rst_n=0, any time, including mid-RUN) immediately and asynchronously forces:
  - state=IDLE, ready=1, done=0;
  - work=0, cnt=0, op_r=000;
  - result=0, carry=0, zero=0, err=0.
  - An in-flight shift is discarded. The first request can be accepted at the first edge after rst_n rises.
- The shift unit path is purely combinational between work and work. No extra pipeline stage is allowed.

## Test plan
- ASR 0x90 by 3 → result 0xF2, carry 0, zero 0, done in cycle 4, ready low in cycles 1–4.
- ROL 0x81 by 1 → result 0x03, carry 1; LSR 0x01 by 1 → result 0x00, carry 1, zero 1.
- ROR 0xA5 by 7 → result 0x4B, carry 0, done in cycle 8; start pulses during cycles 2–7 ignored (no second done, result unchanged).
- Amount 0, LSL 0x3C → result 0x3C, carry 0, done in cycle 1. Then op 110, data 0x55 → err 1, result 0x55, shift_ctrl stays 010.
- Reset asserted in cycle 3 of LSL 0x0F by 4 → all outputs at reset values immediately, no done. A new LSL 0x0F by 4 after release → 0xF0, carry 0, err 0.

Source files
------------

// File: rtl/shift_sequencer_if.sv
// Request/response bus between the processor control FSM and the shift sequencer.
// The control FSM is the master; the sequencer is the slave.
interface shift_sequencer_if #(
  parameter int AMT_W = 3
);
  logic             start;
  logic [2:0]       op;
  logic [AMT_W-1:0] amount;
  logic [7:0]       data_in;
  logic             ready;
  logic             done;
  logic [7:0]       result;
  logic             carry;
  logic             zero;
  logic             err;

  modport master (
    output start, op, amount, data_in,
    input  ready, done, result, carry, zero, err
  );

  modport slave (
    input  start, op, amount, data_in,
    output ready, done, result, carry, zero, err
  );
endinterface

// File: rtl/shift_sequencer.sv
// Multi-bit shift controller: steps the single-bit shift unit once per clock,
// feeding its output back into the working register until the amount is used up.
//
// state | meaning
// IDLE  | ready=1, waiting for a start strobe
// RUN   | one single-bit shift per edge, cnt counts down to 1
// DONE  | one-cycle done pulse, result/flags valid
module shift_sequencer #(
  parameter int AMT_W = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  shift_sequencer_if.slave    req,
  output logic [2:0]          shift_ctrl,
  output logic [7:0]          shift_data,
  input  logic [7:0]          shift_out
);

  localparam logic [2:0] OP_ROL = 3'd0;
  localparam logic [2:0] OP_LSL = 3'd2;
  localparam logic [2:0] OP_LSR = 3'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nx;
  logic [7:0]       work;
  logic [AMT_W-1:0] cnt;
  logic [2:0]       op_r;
  logic [7:0]       result_r;
  logic             carry_r;
  logic             zero_r;
  logic             err_r;

  logic accept;
  logic op_legal;
  logic amt_zero;
  logic last_step;
  logic out_bit;
  logic ready_c;
  logic done_c;

  assign accept    = (state == IDLE) && req.start;
  assign op_legal  = (req.op <= OP_LSR);
  assign amt_zero  = (req.amount == '0);
  assign last_step = (cnt == AMT_W'(1));
  // Left-moving ops lose the MSB, right-moving ops lose the LSB.
  assign out_bit   = ((op_r == OP_ROL) || (op_r == OP_LSL)) ? work[7] : work[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    ready_c  = 1'b0;
    done_c   = 1'b0;
    case (state)
      IDLE: begin
        ready_c = 1'b1;
        if (req.start) state_nx = (op_legal && !amt_zero) ? RUN : DONE;
      end
      RUN: begin
        if (last_step) state_nx = DONE;
      end
      DONE: begin
        done_c   = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work     <= 8'h00;
      cnt      <= '0;
      op_r     <= OP_ROL;
      result_r <= 8'h00;
      carry_r  <= 1'b0;
      zero_r   <= 1'b0;
      err_r    <= 1'b0;
    end else if (accept) begin
      work    <= req.data_in;
      carry_r <= 1'b0;
      if (op_legal) begin
        // op_r only ever takes legal codes; the shift unit stalls on 101-111.
        op_r  <= req.op;
        cnt   <= req.amount;
        err_r <= 1'b0;
      end else begin
        err_r <= 1'b1;
      end
      if (!op_legal || amt_zero) begin
        result_r <= req.data_in;
        zero_r   <= (req.data_in == 8'h00);
      end
    end else if (state == RUN) begin
      work    <= shift_out;
      cnt     <= cnt - AMT_W'(1);
      carry_r <= out_bit;
      if (last_step) begin
        result_r <= shift_out;
        zero_r   <= (shift_out == 8'h00);
      end
    end
  end

  assign shift_ctrl = op_r;
  assign shift_data = work;
  assign req.ready  = ready_c;
  assign req.done   = done_c;
  assign req.result = result_r;
  assign req.carry  = carry_r;
  assign req.zero   = zero_r;
  assign req.err    = err_r;

endmodule
